// File: rtl/uart_tx_sched.sv
// Round-robin packet scheduler feeding the UART TX FIFO.
// Each frame is SYNC, source id, payload (MSB first), then XOR checksum of id and payload.
module uart_tx_sched #(
  parameter int          NUM_REQ   = 2,
  parameter int          PKT_BYTES = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  localparam int         GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int         PW        = PKT_BYTES * 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*PW-1:0]      pkt_data,
  output logic [NUM_REQ-1:0]         ack,
  input  logic                       tx_full,
  output logic [7:0]                 w_data,
  output logic                       wr_uart,
  output logic                       busy,
  output logic [GW-1:0]              grant_id
);

  typedef enum logic [2:0] {IDLE, HDR, ID, PAY, CSUM} state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        ptr_q, ptr_d, grant_q, grant_d;
  logic [PW-1:0]        shadow_q, shadow_d;
  logic [7:0]           csum_q, csum_d, wdata_q, wdata_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 done_q, done_d, wr_q, wr_d, busy_q, busy_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;

  logic                 found;
  logic [GW-1:0]        win;
  logic                 issue;
  logic [7:0]           pay_byte;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
  end

  // The cycle carrying a write strobe is a gap: tx_full is ignored there.
  assign issue    = !wr_q && !tx_full;
  assign pay_byte = shadow_q[int'(cnt_q)*8 +: 8];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    shadow_d = shadow_q;
    csum_d   = csum_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    ack_d    = '0;
    wdata_d  = wdata_q;
    wr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          shadow_d   = pkt_data[int'(win)*PW +: PW];
          grant_d    = win;
          ptr_d      = win;
          csum_d     = 8'(win);
          ack_d[win] = 1'b1;
          done_d     = 1'b0;
          state_d    = HDR;
        end
      end
      HDR: begin
        if (issue) begin
          wdata_d = SYNC_BYTE;
          wr_d    = 1'b1;
          state_d = ID;
        end
      end
      ID: begin
        if (issue) begin
          wdata_d = 8'(grant_q);
          wr_d    = 1'b1;
          cnt_d   = 4'(PKT_BYTES - 1);
          state_d = PAY;
        end
      end
      PAY: begin
        if (issue) begin
          wdata_d = pay_byte;
          wr_d    = 1'b1;
          csum_d  = csum_q ^ pay_byte;
          if (cnt_q == 4'd0) state_d = CSUM;
          else               cnt_d   = cnt_q - 4'd1;
        end
      end
      CSUM: begin
        // Stay one extra cycle after the checksum write so busy drops after the strobe.
        if (done_q) begin
          state_d = IDLE;
        end else if (issue) begin
          wdata_d = csum_q;
          wr_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= GW'(NUM_REQ - 1);
      grant_q  <= '0;
      shadow_q <= '0;
      csum_q   <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      ack_q    <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      shadow_q <= shadow_d;
      csum_q   <= csum_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      ack_q    <= ack_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
    end
  end

  assign ack      = ack_q;
  assign w_data   = wdata_q;
  assign wr_uart  = wr_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule
